// File: rtl/exp2_pkg.sv
// exp2_pkg: shared types and defaults for the log-domain to linear expander.
// Holds the FSM state encoding, default widths and the accumulator-width helper.
// No logic; imported by exp2_expand.
package exp2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_OUT_W  = 19;
  localparam int DEF_MANT_W = 4;
  localparam int DEF_EXP_W  = 5;

  // The accumulator carries the linear result plus the fraction bits that
  // fall off the bottom when the result is truncated.
  function automatic int acc_width(input int out_w, input int mant_w);
    return out_w + mant_w;
  endfunction

endpackage

// File: rtl/exp2_expand.sv
// exp2_expand: rebuilds floor((2^MANT_W + mant) * 2^exp / 2^MANT_W) from a log-domain value.
// Latency: out_valid rises 1+exp cycles after accept (1 cycle for zero/overflow/exp=0).
// Backpressure: one request in flight; in_ready only in IDLE, result held until out_ready.
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   in_valid/in_ready            request handshake; in_zero, in_exp, in_mant sampled on accept
//   out_valid/out_ready          result handshake; out_val, out_ovf stable while out_valid
module exp2_expand
  import exp2_pkg::*;
#(
  parameter int OUT_W  = DEF_OUT_W,
  parameter int MANT_W = DEF_MANT_W,
  parameter int EXP_W  = DEF_EXP_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_zero,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_val,
  output logic              out_ovf
);

  localparam int ACC_W = acc_width(OUT_W, MANT_W);
  localparam logic [EXP_W-1:0] EXP_OVF  = EXP_W'(OUT_W);
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_ZERO = '0;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [EXP_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_val_q, out_val_d;
  logic               out_ovf_q, out_ovf_d;

  // Gated by reset_n so the block never advertises readiness while held in reset.
  assign in_ready  = reset_n && (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_val   = out_val_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_val_d   = out_val_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Implied leading one sits just above the mantissa bits.
          acc_d = {{(ACC_W-MANT_W-1){1'b0}}, 1'b1, in_mant};
          cnt_d = in_exp;
          ovf_d = 1'b0;
          if (in_zero) begin
            acc_d   = '0;
            state_d = DONE;
          end else if (in_exp >= EXP_OVF) begin
            ovf_d   = 1'b1;
            state_d = DONE;
          end else if (in_exp == EXP_ZERO) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        acc_d = acc_q << 1;
        cnt_d = cnt_q - EXP_ONE;
        if (cnt_q == EXP_ONE) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // First DONE cycle registers the result; after that wait for the consumer.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_val_d   = ovf_q ? '1 : acc_q[ACC_W-1:MANT_W];
          out_ovf_d   = ovf_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_val_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_val_q   <= out_val_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_exp2_expand.sv
module tb_exp2_expand;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_zero;
  logic [4:0]  in_exp;
  logic [3:0]  in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_val;
  logic        out_ovf;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  exp2_expand dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_zero   (in_zero),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: floor((16 + mant) * 2^exp / 16), saturating at exp >= 19.
  function automatic longint ref_val(input bit z, input int e, input int m);
    if (z) return 0;
    if (e >= 19) return (longint'(1) << 19) - 1;
    return (longint'(16 + m) * (longint'(1) << e)) / 16;
  endfunction

  function automatic bit ref_ovf(input bit z, input int e);
    return !z && (e >= 19);
  endfunction

  function automatic int ref_lat(input bit z, input int e);
    return (z || e >= 19) ? 1 : 1 + e;
  endfunction

  // Presents one request, waits for accept, then returns the first valid result
  // and the number of edges from the accept edge to out_valid (-1 on timeout).
  task automatic send(input bit z, input int e, input int m,
                      output logic [18:0] v, output logic o, output int lat);
    int n;
    n = 0;
    in_zero  = z;
    in_exp   = 5'(e);
    in_mant  = 4'(m);
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    // Scramble inputs: the DUT must only use what it sampled on the accept edge.
    in_valid = 1'b0;
    in_zero  = 1'($urandom);
    in_exp   = 5'($urandom);
    in_mant  = 4'($urandom);
    lat = -1;
    v   = 'x;
    o   = 'x;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        v   = out_val;
        o   = out_ovf;
        break;
      end
    end
  endtask

  task automatic drain();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_val !== 19'h0) $display("FAIL reset_out_val got %h exp 0", out_val); else pass_cnt++;
    chk_cnt++; if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf got %b exp 0", out_ovf); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready got %b exp 1", in_ready); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit z; int e; int m; int val; bit ovf; int lat;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[9];
    logic [18:0] v;
    logic o;
    int lat;
    vecs[0] = '{0,  0,  0, 'h1,     0, 1};
    vecs[1] = '{0, 18,  0, 'h40000, 0, 19};
    vecs[2] = '{0, 18, 15, 'h7C000, 0, 19};
    vecs[3] = '{0,  4,  8, 24,      0, 5};
    vecs[4] = '{0,  2,  3, 4,       0, 3};
    vecs[5] = '{0,  1, 15, 3,       0, 2};
    vecs[6] = '{0, 19,  0, 'h7FFFF, 1, 1};
    vecs[7] = '{0, 31,  5, 'h7FFFF, 1, 1};
    vecs[8] = '{1, 31,  7, 0,       0, 1};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].z, vecs[i].e, vecs[i].m, v, o, lat);
      chk_cnt++;
      if (v !== 19'(vecs[i].val))
        $display("FAIL directed_val[%0d] got %h exp %h", i, v, 19'(vecs[i].val));
      else pass_cnt++;
      chk_cnt++;
      if (o !== vecs[i].ovf)
        $display("FAIL directed_ovf[%0d] got %b exp %b", i, o, vecs[i].ovf);
      else pass_cnt++;
      chk_cnt++;
      if (lat != vecs[i].lat)
        $display("FAIL directed_lat[%0d] got %0d exp %0d", i, lat, vecs[i].lat);
      else pass_cnt++;
      drain();
    end
  endtask

  task automatic test_random();
    logic [18:0] v;
    logic o;
    int lat, e, m;
    bit z;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      z = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(19, 31)) : int'($urandom_range(0, 18));
      m = $urandom_range(0, 15);
      send(z, e, m, v, o, lat);
      chk_cnt++;
      if (v !== 19'(ref_val(z, e, m)))
        $display("FAIL random_val z=%0d e=%0d m=%0d got %h exp %h", z, e, m, v, 19'(ref_val(z, e, m)));
      else pass_cnt++;
      chk_cnt++;
      if (o !== ref_ovf(z, e))
        $display("FAIL random_ovf z=%0d e=%0d got %b exp %b", z, e, o, ref_ovf(z, e));
      else pass_cnt++;
      chk_cnt++;
      if (lat != ref_lat(z, e))
        $display("FAIL random_lat z=%0d e=%0d got %0d exp %0d", z, e, lat, ref_lat(z, e));
      else pass_cnt++;
      drain();
    end
  endtask

  task automatic test_hold();
    logic [18:0] v;
    logic o;
    int lat;
    out_ready = 1'b0;
    send(0, 5, 3, v, o, lat);
    chk_cnt++; if (v !== 19'd38) $display("FAIL hold_val got %0d exp 38", v); else pass_cnt++;
    chk_cnt++; if (lat != 6) $display("FAIL hold_lat got %0d exp 6", lat); else pass_cnt++;
    // A competing request during DONE must be ignored.
    in_valid = 1'b1;
    in_zero  = 1'b0;
    in_exp   = 5'd1;
    in_mant  = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL hold_valid[%0d] got %b exp 1", i, out_valid); else pass_cnt++;
      chk_cnt++; if (out_val !== 19'd38) $display("FAIL hold_stable[%0d] got %0d exp 38", i, out_val); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d] got %b exp 0", i, in_ready); else pass_cnt++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL hold_release_valid got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL hold_release_ready got %b exp 1", in_ready); else pass_cnt++;
    chk_cnt++; if (out_val !== 19'd38) $display("FAIL hold_val_kept got %0d exp 38", out_val); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int acc2, v1, v2;
    logic [18:0] val1, val2;
    bit rdy_b, early;
    acc2 = -1; v1 = -1; v2 = -1; early = 0;
    val1 = 'x; val2 = 'x;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_zero   = 1'b0;
    in_exp    = 5'd2;
    in_mant   = 4'd0;
    @(posedge clk); #1;            // edge 0: first request accepted
    in_exp  = 5'd3;
    in_mant = 4'd4;
    for (int e = 1; e <= 15; e++) begin
      rdy_b = in_ready;
      @(posedge clk); #1;
      if (rdy_b && e <= 4) early = 1;
      if (rdy_b && in_valid && acc2 < 0) begin
        acc2     = e;
        in_valid = 1'b0;
      end
      if (out_valid && v1 < 0) begin
        v1 = e; val1 = out_val;
      end else if (out_valid && acc2 >= 0 && v2 < 0) begin
        v2 = e; val2 = out_val;
      end
    end
    chk_cnt++; if (early) $display("FAIL b2b_early_ready got 1 exp 0"); else pass_cnt++;
    chk_cnt++; if (v1 != 3) $display("FAIL b2b_first_valid_edge got %0d exp 3", v1); else pass_cnt++;
    chk_cnt++; if (val1 !== 19'd4) $display("FAIL b2b_first_val got %0d exp 4", val1); else pass_cnt++;
    chk_cnt++; if (acc2 != 5) $display("FAIL b2b_second_accept_edge got %0d exp 5", acc2); else pass_cnt++;
    chk_cnt++; if (v2 != 9) $display("FAIL b2b_second_valid_edge got %0d exp 9", v2); else pass_cnt++;
    chk_cnt++; if (val2 !== 19'd10) $display("FAIL b2b_second_val got %0d exp 10", val2); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [18:0] v;
    logic o;
    int lat, n, seen;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_zero   = 1'b0;
    in_exp    = 5'd10;
    in_mant   = 4'd0;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;            // accept
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;                // third SHIFT cycle
    #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready got %b exp 0", in_ready); else pass_cnt++;
    chk_cnt++; if (out_val !== 19'h0) $display("FAIL midrst_out_val got %h exp 0", out_val); else pass_cnt++;
    chk_cnt++; if (out_ovf !== 1'b0) $display("FAIL midrst_out_ovf got %b exp 0", out_ovf); else pass_cnt++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk_cnt++; if (seen != 0) $display("FAIL midrst_no_valid got %0d exp 0", seen); else pass_cnt++;
    send(0, 3, 0, v, o, lat);
    chk_cnt++; if (v !== 19'd8) $display("FAIL midrst_new_val got %0d exp 8", v); else pass_cnt++;
    chk_cnt++; if (lat != 4) $display("FAIL midrst_new_lat got %0d exp 4", lat); else pass_cnt++;
    drain();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_zero   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/exp2_expand.md
Name: exp2_expand

Overview:
- Inverse of the floor-log2 block. Takes a log-domain value (integer exponent plus fractional mantissa bits below the implied leading one) and rebuilds the linear unsigned value.
- The linear value is floor((2^MANT_W + mant) * 2^exp / 2^MANT_W).
- Iterative design: one left-shift per clock, with a valid/ready handshake on both sides.
- Sits downstream of log-domain arithmetic, converting results back to the 19-bit linear sample domain.

Parameters:
- OUT_W, 19, linear output width in bits.
- MANT_W, 4, fractional mantissa bits below the implied leading one (>=0).
- EXP_W, 5, exponent input width; must satisfy 2^EXP_W > OUT_W.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- in_zero  input  1  request encodes linear zero; in_exp and in_mant are ignored.
- in_exp  input  EXP_W  unsigned exponent (floor log2 of result).
- in_mant  input  MANT_W  fraction bits below the leading one.
- out_valid  output  1  result valid, held until accepted.
- out_ready  input  1  consumer accepts the result.
- out_val  output  OUT_W  linear result.
- out_ovf  output  1  in_exp >= OUT_W; out_val is saturated.

Behaviour:
- Reset (async, reset_n low): state=IDLE, in_ready=0 while reset_n low then 1 in IDLE, out_valid=0, out_val=0, out_ovf=0, internal accumulator=0, shift counter=0.
- Accept: in_valid && in_ready on a rising edge. in_ready=1 only in IDLE, so there is no acceptance in SHIFT or DONE.
- Accumulator width is OUT_W+MANT_W. It loads {zeros, 1'b1, in_mant} (leading one at bit MANT_W). Counter loads in_exp.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, on accept:
  - in_zero=1 -> acc=0, ovf=0, go DONE.
  - else in_exp >= OUT_W -> ovf=1, go DONE.
  - else in_exp==0 -> go DONE.
  - else go SHIFT.
  - Priority is in the order listed.
- SHIFT:
  - Each cycle: acc <= acc<<1, counter <= counter-1.
  - When counter reaches 1 on the current edge, the shift happens and the FSM goes DONE.
  - Exactly in_exp shifts are performed.
- DONE:
  - out_valid=1.
  - out_val = ovf ? all-ones : acc[OUT_W+MANT_W-1:MANT_W]. This truncates fraction bits (floor).
  - out_ovf = ovf.
  - out_val and out_ovf are registered and stable for as long as out_valid=1.
  - On out_valid && out_ready -> IDLE, out_valid=0 next cycle. out_val holds its last value.
- Latency:
  - Accept at edge N -> out_valid rises after edge N+1+e, where e = in_exp for normal requests and e = 0 for zero, overflow, or exp=0.
  - Throughput is one request per latency+2 cycles with out_ready tied high (the DONE->IDLE cycle is counted).
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Boundaries:
  - exp=OUT_W-1 with mant=all-ones -> leading one at the MSB, no overflow, OUT_W-1 shifts.
  - MANT_W=0 -> result is a pure power of two.
  - in_valid asserted during SHIFT or DONE is ignored; the request stays pending until IDLE.
  - out_ready low holds DONE indefinitely.
- reset_n low mid-SHIFT or mid-DONE: immediate return to reset values. The in-flight result is discarded; no out_valid pulse.
- Inputs are sampled only on the accept edge. Changes to inputs afterwards have no effect.

Decomposition:
- Package exp2_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - default constants OUT_W=19, MANT_W=4, EXP_W=5;
  - a function giving accumulator width OUT_W+MANT_W.
- Single module; no sub-module. The shift datapath is too small to split out.

Test Plan:
- exp=0, mant=0, out_ready=1 -> out_val=1, out_ovf=0, out_valid one cycle after accept edge.
- exp=18, mant=0 -> out_val=0x40000 with out_valid 19 edges after accept. Then exp=18, mant=4'b1111 -> out_val=0x7C000.
- exp=4, mant=4'b1000 -> 24. exp=2, mant=4'b0011 -> 4 (floor of 4.75). exp=1, mant=4'b1111 -> 3.
- exp=19, and exp=31 -> out_val=0x7FFFF, out_ovf=1, out_valid 1 cycle after accept. in_zero=1 with exp=31 -> out_val=0, out_ovf=0.
- Handshake:
  - out_ready held low 5 cycles in DONE -> out_val/out_valid stable and in_ready=0 throughout.
  - in_valid held high continuously -> second request accepted only in the IDLE cycle after the first handshake.
- Reset: reset_n pulsed low on the 3rd SHIFT cycle of exp=10 -> all outputs return to reset values immediately. No out_valid afterwards. A new request exp=3, mant=0 then yields 8.
